bus_arbiter: RTL

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Arbitrates the instruction-fetch and load/store requesters onto one shared bus port.
// At most one transaction is in flight. Data has fixed priority over fetches.
module bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        i_stall,
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        d_stall,
  input  logic        pipe_stall,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [2:0] {IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA} arbState_t;

  arbState_t state, nextState;
  logic      iDone, dDone, discard;
  logic      launchData, launchInst, keepResult;

  // NOTE: every signal written below gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    launchData = 1'b0;
    launchInst = 1'b0;
    keepResult = 1'b0;
    nextState  = state;
    unique case (state)
      IDLE: begin
        launchData = data_en && !dDone && !flush;
        launchInst = !launchData && inst_en && !iDone && !flush;
        if (launchData)      nextState = D_ADDR;
        else if (launchInst) nextState = I_ADDR;
      end
      I_ADDR: if (bus_addr_ok) nextState = I_DATA;
      D_ADDR: if (bus_addr_ok) nextState = D_DATA;
      I_DATA, D_DATA: begin
        // A flush arriving in the very cycle of the return also discards it.
        keepResult = bus_data_ok && !discard && !flush;
        if (bus_data_ok) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iDone      <= 1'b0;
      dDone      <= 1'b0;
      discard    <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      if (keepResult && state == I_DATA) iDone <= 1'b1;
      else if (flush || !pipe_stall)     iDone <= 1'b0;
      if (keepResult && state == D_DATA) dDone <= 1'b1;
      else if (flush || !pipe_stall)     dDone <= 1'b0;
      if (keepResult && state == I_DATA)            inst_rdata <= bus_rdata;
      if (keepResult && state == D_DATA && !bus_wr) data_rdata <= bus_rdata;
      discard <= (nextState != IDLE) && (discard || flush);
    end
  end

  // Bus attributes are captured at launch and held for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_wr    <= 1'b0;
      bus_size  <= 2'd0;
      bus_addr  <= '0;
      bus_wdata <= '0;
    end else if (launchData) begin
      bus_wr    <= |data_wen;
      bus_size  <= data_size;
      bus_addr  <= data_addr;
      bus_wdata <= data_wdata;
    end else if (launchInst) begin
      bus_wr    <= 1'b0;
      bus_size  <= 2'd2;
      bus_addr  <= inst_addr;
      bus_wdata <= '0;
    end
  end

  assign bus_req = (state == I_ADDR) || (state == D_ADDR);
  assign i_stall = inst_en && !iDone;
  assign d_stall = data_en && !dDone;

endmodule
